// File: rtl/accum_zone_responder.sv
`default_nettype none
// ============================================================================
// Module      : accum_zone_responder
// Description : Responder end of the accumulator command/data protocol for a
//               single zone. Accepts plain or accumulating write commands
//               (command and data handshaken together in one cycle) and read
//               commands that return a single-cycle rvalid response. Owns
//               NUM_BANKS synchronous-read memory banks and performs a masked
//               per-lane read-modify-write for accumulation.
//
// Ports       : clk       - rising-edge clock
//               rst       - synchronous active-high reset
//               wr_valid  - write command valid
//               wr_ready  - write command accepted
//               wr_addr   - write word address
//               wr_mask   - per-bank write enable
//               accum_en  - 1: mem += wdata, 0: mem = wdata
//               wvalid    - write data valid
//               wready    - write data accepted
//               wdata     - write data, lane b at [b*DATA_WIDTH +: DATA_WIDTH]
//               rd_valid  - read command valid
//               rd_ready  - read command accepted
//               rd_addr   - read word address
//               rd_mask   - per-bank read enable (disabled lanes return 0)
//               rvalid    - read response valid, one-cycle pulse
//               rdata     - read response lanes, held until next response
//               busy      - operation in flight (FSM not idle)
//
// Revision    : 1.0 - initial release
// ============================================================================
module accum_zone_responder #(
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [NUM_BANKS-1:0]            wr_mask,
    input  logic                            accum_en,
    input  logic                            wvalid,
    output logic                            wready,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] wdata,
    input  logic                            rd_valid,
    output logic                            rd_ready,
    input  logic [ADDR_WIDTH-1:0]           rd_addr,
    input  logic [NUM_BANKS-1:0]            rd_mask,
    output logic                            rvalid,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] rdata,
    output logic                            busy
);

    localparam int       c_DEPTH     = 1 << ADDR_WIDTH;
    localparam int       c_LANES_W   = NUM_BANKS * DATA_WIDTH;

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_WR      = 3'd1;
    localparam logic [2:0] c_S_ACC_RD  = 3'd2;
    localparam logic [2:0] c_S_ACC_WB  = 3'd3;
    localparam logic [2:0] c_S_RD_WAIT = 3'd4;
    localparam logic [2:0] c_S_RD_RESP = 3'd5;

    // ------------------------------------------------------------------
    // State and holding registers
    // ------------------------------------------------------------------
    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic                  r_pref_rd;     // 1: next contested cycle goes to read
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [NUM_BANKS-1:0]  r_wr_mask;
    logic [NUM_BANKS-1:0]  r_rd_mask;
    logic [c_LANES_W-1:0]  r_wdata;
    logic [c_LANES_W-1:0]  r_rdata;

    // ------------------------------------------------------------------
    // Handshake and arbitration
    // ------------------------------------------------------------------
    logic                  w_idle;
    logic                  w_wr_req;
    logic                  w_contest;
    logic                  w_wr_grant;
    logic                  w_rd_grant;
    logic                  w_wr_fire;
    logic                  w_rd_fire;

    // A write request only exists once both command and data are offered,
    // so a lone wr_valid or wvalid never competes with a read.
    assign w_idle     = (r_state == c_S_IDLE) & ~rst;
    assign w_wr_req   = wr_valid & wvalid;
    assign w_contest  = w_wr_req & rd_valid;
    assign w_wr_grant = w_wr_req & (~rd_valid | ~r_pref_rd);
    assign w_rd_grant = rd_valid & (~w_wr_req | r_pref_rd);
    assign w_wr_fire  = w_idle & w_wr_grant;
    assign w_rd_fire  = w_idle & w_rd_grant;

    assign wr_ready   = w_wr_fire;
    assign wready     = w_wr_fire;
    assign rd_ready   = w_rd_fire;

    assign busy       = (r_state != c_S_IDLE);
    // The rst term suppresses a response whose RD_RESP cycle collides
    // with a reset.
    assign rvalid     = (r_state == c_S_RD_RESP) & ~rst;
    assign rdata      = r_rdata;

    // ------------------------------------------------------------------
    // Memory port control
    // ------------------------------------------------------------------
    // The bank read is launched in the handshake cycle itself, using the
    // live command address, so old data is ready one cycle later.
    logic                  w_mem_re;
    logic [ADDR_WIDTH-1:0] w_mem_raddr;
    logic                  w_mem_wr_phase;
    logic                  w_mem_acc_phase;
    logic [c_LANES_W-1:0]  w_mem_rd;
    logic [c_LANES_W-1:0]  w_rd_masked;

    assign w_mem_re        = (w_wr_fire & accum_en) | w_rd_fire;
    assign w_mem_raddr     = w_rd_fire ? rd_addr : wr_addr;
    assign w_mem_acc_phase = (r_state == c_S_ACC_WB);
    assign w_mem_wr_phase  = ((r_state == c_S_WR) | w_mem_acc_phase) & ~rst;

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
            logic [DATA_WIDTH-1:0] r_rd_word;
            logic [DATA_WIDTH-1:0] w_new_word;
            logic                  w_we;

            // Accumulation wraps modulo 2^DATA_WIDTH; each lane is independent.
            assign w_new_word = w_mem_acc_phase
                              ? (r_rd_word + r_wdata[b*DATA_WIDTH +: DATA_WIDTH])
                              : r_wdata[b*DATA_WIDTH +: DATA_WIDTH];
            assign w_we       = w_mem_wr_phase & r_wr_mask[b];

            always_ff @(posedge clk) begin
                if (w_we) begin
                    r_mem[r_wr_addr] <= w_new_word;
                end
                if (w_mem_re) begin
                    r_rd_word <= r_mem[w_mem_raddr];
                end
            end

            assign w_mem_rd[b*DATA_WIDTH +: DATA_WIDTH]    = r_rd_word;
            assign w_rd_masked[b*DATA_WIDTH +: DATA_WIDTH] =
                r_rd_mask[b] ? r_rd_word : {DATA_WIDTH{1'b0}};
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_wr_fire) begin
                    w_state_next = accum_en ? c_S_ACC_RD : c_S_WR;
                end else if (w_rd_fire) begin
                    w_state_next = c_S_RD_WAIT;
                end
            end
            c_S_WR:      w_state_next = c_S_IDLE;
            c_S_ACC_RD:  w_state_next = c_S_ACC_WB;
            c_S_ACC_WB:  w_state_next = c_S_IDLE;
            c_S_RD_WAIT: w_state_next = c_S_RD_RESP;
            c_S_RD_RESP: w_state_next = c_S_IDLE;
            default:     w_state_next = c_S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_pref_rd <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_state_next;
            // Only a contested idle cycle moves the pointer: whoever wins
            // now yields the next contest.
            if (w_idle & w_contest) begin
                r_pref_rd <= w_wr_grant;
            end
            if (r_state == c_S_RD_WAIT) begin
                r_rdata <= w_rd_masked;
            end
        end
    end

    // Datapath holding registers need no reset: they are only consumed in
    // states reachable after a handshake has loaded them.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_wr_addr <= wr_addr;
            r_wr_mask <= wr_mask;
            r_wdata   <= wdata;
        end
        if (w_rd_fire) begin
            r_rd_mask <= rd_mask;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accum_zone_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_zone_responder
// Description : Self-checking bench for accum_zone_responder. Stimulus tasks
//               push expected read responses into a scoreboard queue; a
//               monitor pops and compares whenever rvalid is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_zone_responder;

    localparam int NB = 4;
    localparam int AW = 9;
    localparam int DW = 64;
    localparam int LW = NB * DW;

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [NB-1:0] wr_mask;
    logic          accum_en;
    logic          wvalid;
    logic          wready;
    logic [LW-1:0] wdata;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic [NB-1:0] rd_mask;
    logic          rvalid;
    logic [LW-1:0] rdata;
    logic          busy;

    accum_zone_responder #(
        .NUM_BANKS (NB),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr (wr_addr),
        .wr_mask (wr_mask),
        .accum_en(accum_en),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_addr (rd_addr),
        .rd_mask (rd_mask),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [LW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sb[$];
    logic [LW-1:0] last_exp;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [LW-1:0] lanes(input logic [DW-1:0] base, input logic [DW-1:0] step);
        logic [LW-1:0] v;
        for (int b = 0; b < NB; b++) v[b*DW +: DW] = base + step * DW'(b);
        return v;
    endfunction

    // Monitor: every rvalid must match the oldest expectation, both in data
    // and in the cycle it was due.
    always @(negedge clk) begin
        if (rvalid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rvalid_unexpected: actual=1 required=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rdata", rdata, e.data);
                chk_int("rvalid_cycle", cyc, e.cyc);
            end
        end
    end

    // Wait (bounded) at negedges until the write pair is accepted.
    task automatic wait_wr(output int hs);
        bit ok = 0;
        hs = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_ready || wready) begin ok = 1; break; end
        end
        if (!ok) chk_int("wr_accept_timeout", 0, 1);
        else begin
            hs = cyc;
            chk_int("wr_pair_ready", {31'd0, wr_ready & wready}, 1);
        end
    endtask

    task automatic wait_rd(output int hs);
        bit ok = 0;
        hs = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_ready) begin ok = 1; break; end
        end
        if (!ok) chk_int("rd_accept_timeout", 0, 1);
        else hs = cyc;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [NB-1:0] m,
                            input logic acc, input logic [LW-1:0] d);
        int hs;
        int nb;
        @(posedge clk); #1;
        wr_valid = 1; wvalid = 1; wr_addr = a; wr_mask = m; accum_en = acc; wdata = d;
        wait_wr(hs);
        @(posedge clk); #1;
        wr_valid = 0; wvalid = 0;
        nb = acc ? 2 : 1;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            chk_int("busy_during_write", {31'd0, busy}, 1);
        end
        @(negedge clk);
        chk_int("busy_after_write", {31'd0, busy}, 0);
    endtask

    task automatic push_exp(input logic [LW-1:0] d, input int due);
        exp_t e;
        e.data = d;
        e.cyc  = due;
        sb.push_back(e);
        last_exp = d;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [NB-1:0] m, input logic [LW-1:0] d);
        int hs;
        @(posedge clk); #1;
        rd_valid = 1; rd_addr = a; rd_mask = m;
        wait_rd(hs);
        if (hs >= 0) push_exp(d, hs + 2);
        @(posedge clk); #1;
        rd_valid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk_int("response_missing", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int whs;
        int rhs;
        rst = 1; wr_valid = 0; wvalid = 0; rd_valid = 0;
        wr_addr = '0; wr_mask = '0; accum_en = 0; wdata = '0; rd_addr = '0; rd_mask = '0;

        // ---------------- Reset state, requests held high during reset
        repeat (2) @(posedge clk);
        #1;
        wr_valid = 1; wvalid = 1; rd_valid = 1;
        @(negedge clk);
        chk_int("rst_wr_ready", {31'd0, wr_ready}, 0);
        chk_int("rst_wready", {31'd0, wready}, 0);
        chk_int("rst_rd_ready", {31'd0, rd_ready}, 0);
        chk_int("rst_rvalid", {31'd0, rvalid}, 0);
        chk_int("rst_busy", {31'd0, busy}, 0);
        chk("rst_rdata", rdata, '0);
        @(posedge clk); #1;
        wr_valid = 0; wvalid = 0; rd_valid = 0;
        @(posedge clk); #1;
        rst = 0;

        // ---------------- Plain write then read
        do_write(9'h010, 4'hF, 1'b0, lanes(64'hA000_0000_0000_0000, 64'd1));
        do_read(9'h010, 4'hF, lanes(64'hA000_0000_0000_0000, 64'd1));
        drain();

        // ---------------- Accumulate: (10+b) + (20+b) = 30 + 2b
        do_write(9'h030, 4'hF, 1'b0, lanes(64'd10, 64'd1));
        do_write(9'h030, 4'hF, 1'b1, lanes(64'd20, 64'd1));
        do_read(9'h030, 4'hF, {64'd36, 64'd34, 64'd32, 64'd30});
        drain();

        // ---------------- Wraparound on lane 0, other lanes masked off
        do_write(9'h040, 4'hF, 1'b0, {64'd3, 64'd2, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF});
        do_write(9'h040, 4'b0001, 1'b1, {64'd5, 64'd5, 64'd5, 64'd2});
        do_read(9'h040, 4'hF, {64'd3, 64'd2, 64'd1, 64'd1});
        drain();

        // ---------------- Partial write mask and partial read mask
        do_write(9'h050, 4'hF, 1'b0, lanes(64'h100, 64'd1));
        do_write(9'h050, 4'b0101, 1'b0, lanes(64'h200, 64'd1));
        do_read(9'h050, 4'hF, {64'h103, 64'h202, 64'h101, 64'h200});
        do_read(9'h050, 4'b0011, {64'h0, 64'h0, 64'h101, 64'h200});
        drain();
        // All-zero mask: handshake completes, memory untouched
        do_write(9'h050, 4'b0000, 1'b0, lanes(64'hDEAD, 64'd1));
        do_write(9'h050, 4'b0000, 1'b1, lanes(64'hBEEF, 64'd1));
        do_read(9'h050, 4'hF, {64'h103, 64'h202, 64'h101, 64'h200});
        drain();

        // ---------------- Split valids
        do_write(9'h060, 4'hF, 1'b0, lanes(64'h5, 64'd1));
        @(posedge clk); #1;
        wr_valid = 1; wvalid = 0; wr_addr = 9'h060; wr_mask = 4'hF; accum_en = 0;
        wdata = lanes(64'h7, 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_int("split_wr_ready", {31'd0, wr_ready}, 0);
            chk_int("split_wready", {31'd0, wready}, 0);
            chk_int("split_busy", {31'd0, busy}, 0);
        end
        do_read(9'h060, 4'hF, lanes(64'h5, 64'd1));
        drain();
        @(posedge clk); #1;
        wvalid = 1;
        wait_wr(whs);
        @(posedge clk); #1;
        wr_valid = 0; wvalid = 0;
        do_read(9'h060, 4'hF, lanes(64'h7, 64'd1));
        drain();

        // ---------------- Arbitration: first contest goes to write
        @(posedge clk); #1;
        wr_valid = 1; wvalid = 1; wr_addr = 9'h070; wr_mask = 4'hF; accum_en = 0;
        wdata = lanes(64'h900, 64'd1);
        rd_valid = 1; rd_addr = 9'h070; rd_mask = 4'hF;
        @(negedge clk);
        whs = cyc;
        chk_int("arb1_wr_ready", {31'd0, wr_ready}, 1);
        chk_int("arb1_rd_ready", {31'd0, rd_ready}, 0);
        @(posedge clk); #1;
        wr_valid = 0; wvalid = 0;
        wait_rd(rhs);
        chk_int("arb1_rd_accept_cycle", rhs, whs + 2);
        if (rhs >= 0) push_exp(lanes(64'h900, 64'd1), rhs + 2);
        @(posedge clk); #1;
        rd_valid = 0;
        drain();

        // ---------------- Second contest goes to read
        @(posedge clk); #1;
        wr_valid = 1; wvalid = 1; wr_addr = 9'h070; wr_mask = 4'hF; accum_en = 0;
        wdata = lanes(64'hB00, 64'd1);
        rd_valid = 1; rd_addr = 9'h070; rd_mask = 4'hF;
        @(negedge clk);
        rhs = cyc;
        chk_int("arb2_rd_ready", {31'd0, rd_ready}, 1);
        chk_int("arb2_wr_ready", {31'd0, wr_ready}, 0);
        push_exp(lanes(64'h900, 64'd1), rhs + 2);
        @(posedge clk); #1;
        rd_valid = 0;
        wait_wr(whs);
        chk_int("arb2_wr_accept_cycle", whs, rhs + 3);
        @(posedge clk); #1;
        wr_valid = 0; wvalid = 0;
        do_read(9'h070, 4'hF, lanes(64'hB00, 64'd1));
        drain();

        // ---------------- Reset during ACC_RD drops the accumulate
        do_write(9'h080, 4'hF, 1'b0, lanes(64'h40, 64'd1));
        @(posedge clk); #1;
        wr_valid = 1; wvalid = 1; wr_addr = 9'h080; wr_mask = 4'hF; accum_en = 1;
        wdata = lanes(64'h1, 64'd0);
        wait_wr(whs);
        @(posedge clk); #1;
        wr_valid = 0; wvalid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk_int("midrst_busy", {31'd0, busy}, 0);
        chk_int("midrst_rvalid", {31'd0, rvalid}, 0);
        chk("midrst_rdata", rdata, '0);
        do_read(9'h080, 4'hF, lanes(64'h40, 64'd1));
        drain();

        // rdata holds after rvalid falls
        repeat (3) @(negedge clk);
        chk("rdata_hold", rdata, last_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
